// File: rtl/dot_product_seq_if.sv
// Handshake and DSP-slice signal bundle for dot_product_seq.
// out_len exists only when DOTSEQ_LEN_EN is defined.
interface dot_product_seq_if #(
  parameter int unsigned SIZE1 = 18,
  parameter int unsigned SIZE3 = 48
);
  logic             in_valid;
  logic             in_ready;
  logic [SIZE1-1:0] in_a;
  logic [SIZE1-1:0] in_b;
  logic             in_last;
  logic [SIZE1-1:0] dsp_a;
  logic [SIZE1-1:0] dsp_b;
  logic [7:0]       dsp_opmode;
  logic [SIZE3-1:0] dsp_p;
  logic             out_valid;
  logic             out_ready;
  logic [SIZE3-1:0] out_data;
`ifdef DOTSEQ_LEN_EN
  logic [7:0]       out_len;
`endif

  // Stimulus/consumer side (testbench or parent logic plus the DSP slice).
  modport master (
    output in_valid, in_a, in_b, in_last, dsp_p, out_ready,
`ifdef DOTSEQ_LEN_EN
    input  out_len,
`endif
    input  in_ready, dsp_a, dsp_b, dsp_opmode, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_a, in_b, in_last, dsp_p, out_ready,
`ifdef DOTSEQ_LEN_EN
    output out_len,
`endif
    output in_ready, dsp_a, dsp_b, dsp_opmode, out_valid, out_data
  );
endinterface

// File: rtl/dot_product_seq.sv
// Sequences operand beats into an external DSP slice and queues its accumulated P per vector.
// Define DOTSEQ_LEN_EN to add out_len (saturating element count of the head result).
module dot_product_seq #(
  parameter int unsigned SIZE1 = 18,
  parameter int unsigned SIZE3 = 48,
  parameter int unsigned LAT   = 3
) (
  input logic              CLK,
  input logic              RSTN,
  dot_product_seq_if.slave bus
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic             accept, first, push, pop;
  logic [SIZE1-1:0] a_q, b_q;
  logic             first_q, last_q;
  logic [7:0]       opmode_q;
  logic [LAT-1:0]   last_sr_q;
  logic [LAT:0]     last_sr_ext;
  logic [1:0]       inflight_q, inflight_d;
  logic [SIZE3-1:0] mem_q [2];
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       count_q, count_d;

  assign accept = bus.in_valid & bus.in_ready;
  assign first  = accept & (state_q == IDLE);
  assign push   = last_sr_q[LAT-1];
  assign pop    = bus.out_valid & bus.out_ready;

  always_comb begin
    state_d = state_q;
    if (accept) state_d = bus.in_last ? IDLE : RUN;
  end

  assign last_sr_ext = {last_sr_q, last_q};

  // Issue stage: operands now, opmode one cycle later to line up with the slice MREG.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      first_q   <= 1'b0;
      last_q    <= 1'b0;
      opmode_q  <= 8'h00;
      last_sr_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= accept ? bus.in_a : '0;
      b_q       <= accept ? bus.in_b : '0;
      first_q   <= first;
      last_q    <= accept & bus.in_last;
      opmode_q  <= first_q ? 8'h01 : 8'h09;
      last_sr_q <= last_sr_ext[LAT-1:0];
    end
  end

  assign bus.dsp_a      = a_q;
  assign bus.dsp_b      = b_q;
  assign bus.dsp_opmode = opmode_q;

  always_comb begin
    inflight_d = inflight_q;
    unique case ({accept & bus.in_last, push})
      2'b10:   inflight_d = inflight_q + 2'd1;
      2'b01:   inflight_d = inflight_q - 2'd1;
      default: ;
    endcase
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      inflight_q <= 2'd0;
      count_q    <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      mem_q[0]   <= '0;
      mem_q[1]   <= '0;
    end else begin
      inflight_q <= inflight_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_q ^ push;
      rd_ptr_q   <= rd_ptr_q ^ pop;
      if (push) mem_q[wr_ptr_q] <= bus.dsp_p;
    end
  end

  // Admission counts results still in the slice so the 2-entry FIFO can never overflow.
  assign bus.in_ready  = ({1'b0, count_q} + {1'b0, inflight_q}) < 3'd2;
  assign bus.out_valid = (count_q != 2'd0);
  assign bus.out_data  = mem_q[rd_ptr_q];

`ifdef DOTSEQ_LEN_EN
  logic [7:0] len_cnt_q, beat_len;
  logic [7:0] len_pipe_q [LAT+1];
  logic [7:0] len_mem_q [2];

  always_comb begin
    beat_len = 8'd1;
    if (!first) beat_len = (len_cnt_q == 8'hff) ? 8'hff : len_cnt_q + 8'd1;
  end

  // Length travels beside the last tag so it lands in the FIFO with its result.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      len_cnt_q    <= 8'd0;
      len_mem_q[0] <= 8'd0;
      len_mem_q[1] <= 8'd0;
      for (int unsigned i = 0; i <= LAT; i++) len_pipe_q[i] <= 8'd0;
    end else begin
      if (accept) len_cnt_q <= beat_len;
      len_pipe_q[0] <= beat_len;
      for (int unsigned i = 1; i <= LAT; i++) len_pipe_q[i] <= len_pipe_q[i-1];
      if (push) len_mem_q[wr_ptr_q] <= len_pipe_q[LAT];
    end
  end

  assign bus.out_len = len_mem_q[rd_ptr_q];
`endif

endmodule

// File: tb/tb_dot_product_seq.sv
// Self-checking bench for dot_product_seq with a behavioural DSP slice (A1/M/P registered).
// Define DOTSEQ_LEN_EN to also exercise out_len.
module tb_dot_product_seq;
  localparam int unsigned SIZE1 = 18;
  localparam int unsigned SIZE3 = 48;
  localparam int unsigned LAT   = 3;

  logic CLK;
  logic RSTN;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  dot_product_seq_if #(.SIZE1(SIZE1), .SIZE3(SIZE3)) bus ();

  dot_product_seq #(.SIZE1(SIZE1), .SIZE3(SIZE3), .LAT(LAT)) dut (
    .CLK  (CLK),
    .RSTN (RSTN),
    .bus  (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Slice model: bit0 of OPMODE selects X=M, bit3 selects Z=P; never reset by RSTN.
  logic [SIZE1-1:0] a1 = '0, b1 = '0;
  logic [SIZE3-1:0] m = '0, p = '0;
  logic [7:0]       op1 = '0;
  always @(posedge CLK) begin
    a1  <= bus.dsp_a;
    b1  <= bus.dsp_b;
    m   <= SIZE3'(a1) * SIZE3'(b1);
    op1 <= bus.dsp_opmode;
    p   <= (op1[0] ? m : '0) + (op1[3] ? p : '0);
  end
  assign bus.dsp_p = p;

  // Record every popped result with the cycle it was visible.
  logic [SIZE3-1:0] got_d [$];
  int               got_c [$];
  logic [7:0]       got_l [$];
  always @(negedge CLK) begin
    if (RSTN && bus.out_valid && bus.out_ready) begin
      got_d.push_back(bus.out_data);
      got_c.push_back(cyc);
`ifdef DOTSEQ_LEN_EN
      got_l.push_back(bus.out_len);
`else
      got_l.push_back(8'd0);
`endif
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic clear_got();
    got_d.delete(); got_c.delete(); got_l.delete();
  endtask

  task automatic send(input logic [SIZE1-1:0] a, input logic [SIZE1-1:0] b, input logic last,
                      output int acc);
    int n = 0;
    bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b; bus.in_last = last;
    while (!bus.in_ready && n < 300) begin @(posedge CLK); #1; n++; end
    checks++;
    if (!bus.in_ready) begin
      errors++; acc = -1;
      $display("FAIL send_timeout: in_ready=%0b required 1", bus.in_ready);
    end else begin
      @(posedge CLK); #1; acc = cyc;
    end
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_last = 1'b0;
  endtask

  task automatic wait_results(input int k);
    int n = 0;
    while (got_d.size() < k && n < 400) begin @(posedge CLK); #1; n++; end
    checks++;
    if (got_d.size() != k) begin
      errors++; $display("FAIL result_count: got %0d required %0d", got_d.size(), k);
    end
  endtask

  task automatic test_reset();
    RSTN = 1'b1; #2 RSTN = 1'b0;
    repeat (2) @(negedge CLK);
    checks += 6;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b required 0", bus.out_valid); end
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b required 1", bus.in_ready); end
    if (bus.dsp_a !== '0) begin errors++; $display("FAIL rst_dsp_a: got %0d required 0", bus.dsp_a); end
    if (bus.dsp_b !== '0) begin errors++; $display("FAIL rst_dsp_b: got %0d required 0", bus.dsp_b); end
    if (bus.dsp_opmode !== 8'h00) begin errors++; $display("FAIL rst_opmode: got %h required 00", bus.dsp_opmode); end
    if (bus.out_data !== '0) begin errors++; $display("FAIL rst_out_data: got %0d required 0", bus.out_data); end
    RSTN = 1'b1;
    @(posedge CLK); #1; idle(1);
    checks += 3;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL post_rst_out_valid: got %b required 0", bus.out_valid); end
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready: got %b required 1", bus.in_ready); end
    if (bus.dsp_opmode !== 8'h09) begin errors++; $display("FAIL post_rst_opmode: got %h required 09", bus.dsp_opmode); end
  endtask

  task automatic test_basic();
    int acc0, acc1;
    clear_got(); bus.out_ready = 1'b1;
    send(18'd2, 18'd3, 1'b0, acc0);
    checks += 3;
    if (bus.dsp_a !== 18'd2) begin errors++; $display("FAIL basic_dsp_a: got %0d required 2", bus.dsp_a); end
    if (bus.dsp_b !== 18'd3) begin errors++; $display("FAIL basic_dsp_b: got %0d required 3", bus.dsp_b); end
    if (bus.dsp_opmode !== 8'h09) begin errors++; $display("FAIL basic_op_idle: got %h required 09", bus.dsp_opmode); end
    send(18'd4, 18'd5, 1'b1, acc1);
    checks += 2;
    if (bus.dsp_a !== 18'd4) begin errors++; $display("FAIL basic_dsp_a2: got %0d required 4", bus.dsp_a); end
    if (bus.dsp_opmode !== 8'h01) begin errors++; $display("FAIL basic_op_first: got %h required 01", bus.dsp_opmode); end
    idle(1);
    checks += 2;
    if (bus.dsp_a !== '0) begin errors++; $display("FAIL basic_dsp_a_idle: got %0d required 0", bus.dsp_a); end
    if (bus.dsp_opmode !== 8'h09) begin errors++; $display("FAIL basic_op_acc: got %h required 09", bus.dsp_opmode); end
    wait_results(1);
    checks += 3;
    if (got_d[0] !== 48'd26) begin errors++; $display("FAIL basic_data: got %0d required 26", got_d[0]); end
    if (got_c[0] - acc1 != int'(LAT) + 1) begin
      errors++; $display("FAIL basic_latency: got %0d required %0d", got_c[0] - acc1, LAT + 1);
    end
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL basic_one_cycle: out_valid %b required 0", bus.out_valid); end
`ifdef DOTSEQ_LEN_EN
    checks++;
    if (got_l[0] !== 8'd2) begin errors++; $display("FAIL basic_len: got %0d required 2", got_l[0]); end
`endif
  endtask

  task automatic test_bubbles();
    int acc;
    clear_got(); bus.out_ready = 1'b1;
    send(18'd2, 18'd3, 1'b0, acc);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      checks++;
      if (bus.dsp_a !== '0) begin errors++; $display("FAIL bubble_dsp_a: got %0d required 0", bus.dsp_a); end
      if (i > 0) begin
        checks++;
        if (bus.dsp_opmode !== 8'h09) begin errors++; $display("FAIL bubble_opmode: got %h required 09", bus.dsp_opmode); end
      end
    end
    send(18'd4, 18'd5, 1'b1, acc);
    checks++;
    if (bus.dsp_opmode !== 8'h09) begin errors++; $display("FAIL bubble_opmode_last: got %h required 09", bus.dsp_opmode); end
    wait_results(1);
    checks++;
    if (got_d[0] !== 48'd26) begin errors++; $display("FAIL bubble_data: got %0d required 26", got_d[0]); end
  endtask

  task automatic test_back_to_back();
    int acc0, acc1;
    clear_got(); bus.out_ready = 1'b1;
    send(18'd1, 18'd1, 1'b1, acc0);
    send(18'd2, 18'd2, 1'b1, acc1);
    wait_results(2);
    checks += 3;
    if (acc1 - acc0 != 1) begin errors++; $display("FAIL b2b_gap: got %0d required 1", acc1 - acc0); end
    if (got_d[0] !== 48'd1) begin errors++; $display("FAIL b2b_first: got %0d required 1", got_d[0]); end
    if (got_d[1] !== 48'd4) begin errors++; $display("FAIL b2b_second: got %0d required 4", got_d[1]); end
  endtask

  task automatic test_backpressure();
    int acc0, acc1, acc2;
    clear_got(); bus.out_ready = 1'b0;
    send(18'd1, 18'd1, 1'b1, acc0);
    send(18'd2, 18'd2, 1'b1, acc1);
    checks++;
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_drop: got %b required 0", bus.in_ready); end
    fork
      send(18'd3, 18'd3, 1'b1, acc2);
      begin
        idle(10);
        checks += 2;
        if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_full: got %b required 0", bus.in_ready); end
        if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid: got %b required 1", bus.out_valid); end
        bus.out_ready = 1'b1;
      end
    join
    wait_results(3);
    checks += 4;
    if (got_d[0] !== 48'd1) begin errors++; $display("FAIL bp_r0: got %0d required 1", got_d[0]); end
    if (got_d[1] !== 48'd4) begin errors++; $display("FAIL bp_r1: got %0d required 4", got_d[1]); end
    if (got_d[2] !== 48'd9) begin errors++; $display("FAIL bp_r2: got %0d required 9", got_d[2]); end
    if (!(acc2 > got_c[0] + 1)) begin
      errors++; $display("FAIL bp_third_accept: accepted cycle %0d required after %0d", acc2, got_c[0] + 1);
    end
  endtask

  task automatic test_reset_mid();
    int acc;
    clear_got(); bus.out_ready = 1'b1;
    send(18'd7, 18'd7, 1'b0, acc);
    RSTN = 1'b0;
    idle(2);
    checks += 2;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready: got %b required 1", bus.in_ready); end
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b required 0", bus.out_valid); end
    RSTN = 1'b1;
    idle(1);
    send(18'd1, 18'd2, 1'b1, acc);
    idle(1);
    checks++;
    if (bus.dsp_opmode !== 8'h01) begin errors++; $display("FAIL mid_first_tag: got %h required 01", bus.dsp_opmode); end
    wait_results(1);
    idle(10);
    checks += 2;
    if (got_d[0] !== 48'd2) begin errors++; $display("FAIL mid_data: got %0d required 2", got_d[0]); end
    if (got_d.size() != 1) begin errors++; $display("FAIL mid_stale: got %0d results required 1", got_d.size()); end
  endtask

  task automatic test_random();
    logic [SIZE3-1:0] exp_d [$];
    int               exp_l [$];
    logic [SIZE1-1:0] a, b;
    logic [SIZE3-1:0] sum;
    int               len, acc;
    bit               done = 1'b0;
    clear_got();
    fork
      begin
        for (int v = 0; v < 8; v++) begin
          len = $urandom_range(1, 6); sum = '0;
          for (int e = 0; e < len; e++) begin
            a = SIZE1'($urandom); b = SIZE1'($urandom);
            sum += SIZE3'(a) * SIZE3'(b);
            send(a, b, e == len - 1, acc);
            idle($urandom_range(0, 2));
          end
          exp_d.push_back(sum); exp_l.push_back(len);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin bus.out_ready = 1'($urandom_range(0, 1)); idle(1); end
        bus.out_ready = 1'b1;
      end
    join
    wait_results(exp_d.size());
    for (int i = 0; i < exp_d.size(); i++) begin
      checks++;
      if (got_d[i] !== exp_d[i]) begin
        errors++; $display("FAIL rand_data[%0d]: got %0d required %0d", i, got_d[i], exp_d[i]);
      end
`ifdef DOTSEQ_LEN_EN
      checks++;
      if (int'(got_l[i]) != exp_l[i]) begin
        errors++; $display("FAIL rand_len[%0d]: got %0d required %0d", i, got_l[i], exp_l[i]);
      end
`endif
    end
  endtask

`ifdef DOTSEQ_LEN_EN
  task automatic test_len_saturate();
    int acc;
    clear_got(); bus.out_ready = 1'b1;
    for (int e = 0; e < 300; e++) send(18'd1, 18'd1, e == 299, acc);
    wait_results(1);
    checks += 2;
    if (got_l[0] !== 8'd255) begin errors++; $display("FAIL len_sat: got %0d required 255", got_l[0]); end
    if (got_d[0] !== 48'd300) begin errors++; $display("FAIL len_sat_data: got %0d required 300", got_d[0]); end
  endtask
`endif

  initial begin
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_last = 1'b0;
    bus.out_ready = 1'b1;
    test_reset();
    test_basic();
    test_bubbles();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_random();
`ifdef DOTSEQ_LEN_EN
    test_len_saturate();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dot_product_seq.md
DOT_PRODUCT_SEQ -- requirements
Module: dot_product_seq

Interface
REQ-001 The block SHALL have parameter SIZE1, default 18, giving the operand width for A and B.
REQ-002 The block SHALL have parameter SIZE3, default 48, giving the DSP P and result width.
REQ-003 The block SHALL have parameter LAT, default 3, giving the cycles from operand issue to valid P at the DSP slice (A1REG=1, MREG=1, PREG=1).
REQ-004 The block SHALL use one clock, CLK; reset is asynchronous and active-low, named RSTN.
REQ-005 The block SHALL have these ports, each as name, direction, width, meaning:
- CLK, in, 1, clock.
- RSTN, in, 1, async active-low reset.
- in_valid, in, 1, input beat valid.
- in_ready, out, 1, block accepts the beat.
- in_a, in, SIZE1, multiplicand.
- in_b, in, SIZE1, multiplier.
- in_last, in, 1, final element of the vector.
- dsp_a, out, SIZE1, drives the slice A input.
- dsp_b, out, SIZE1, drives the slice B input.
- dsp_opmode, out, 8, drives the slice OPMODE input.
- dsp_p, in, SIZE3, slice P output.
- out_valid, out, 1, result available.
- out_ready, in, 1, consumer takes the result.
- out_data, out, SIZE3, dot-product result.

Function
REQ-006 A beat SHALL be accepted in a cycle where in_valid and in_ready are both 1.
REQ-007 dsp_a and dsp_b SHALL be registered: the accepted in_a/in_b appear the cycle after acceptance; in every cycle without acceptance they SHALL be 0.
REQ-008 The FSM SHALL have state IDLE (no vector open) and state RUN (vector open).
- IDLE, accepted non-last beat: go to RUN.
- RUN, accepted last beat: go to IDLE.
- IDLE, accepted last beat (1-element vector): stay in IDLE.
REQ-009 The first beat of a vector (accepted in IDLE) SHALL be tagged first; all other beats, and all non-accepting cycles, SHALL be tagged accumulate.
REQ-010 dsp_opmode SHALL lag dsp_a by exactly one cycle: 8'h01 (X=M, Z=0) for a first beat, 8'h09 (X=M, Z=P) otherwise, including zero bubbles.
REQ-011 Bubbles (in_valid=0 mid-vector) SHALL issue A=B=0 so that P is unchanged; the result SHALL be independent of bubble count.
REQ-012 A LAT-deep shift register SHALL carry the last tag; when it emerges, dsp_p SHALL be pushed into a 2-entry result FIFO in that same cycle.
REQ-013 inflight SHALL count last beats issued but not yet captured, range 0..2.
REQ-014 in_ready SHALL equal 1 when (fifo_count + inflight) < 2, and 0 otherwise; no result is ever dropped.
REQ-015 out_valid SHALL be 1 when fifo_count > 0, and out_data SHALL be the FIFO head; a pop occurs on out_valid and out_ready.
REQ-016 A simultaneous push and pop SHALL keep fifo_count unchanged, and order SHALL be preserved.
REQ-017 Back-to-back vectors SHALL be supported with zero gap cycles, because the first-beat opmode clears the accumulation.
REQ-018 Products and sums SHALL wrap modulo 2^SIZE3, exactly as the slice produces them; the block performs no arithmetic.

Reset
REQ-019 While RSTN=0, state SHALL be IDLE and dsp_a, dsp_b, dsp_opmode, the shift register, inflight, FIFO pointers, out_data and fifo_count SHALL all be 0.
REQ-020 During and after reset, out_valid SHALL be 0 and in_ready SHALL be 1.
REQ-021 Reset mid-vector SHALL abandon the partial vector; the first beat after release SHALL be tagged first.

Configuration
REQ-022 With DOTSEQ_LEN_EN defined, the block SHALL add output out_len[7:0], the element count of the head result; the count saturates at 255, bubbles are excluded, and it is stored alongside out_data in the FIFO.
REQ-023 Without DOTSEQ_LEN_EN, port out_len and its counter and storage SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-024 Beats (2,3),(4,5,last), out_ready=1 -> out_valid for one cycle with out_data=26, appearing LAT+1 cycles after the last acceptance.
REQ-025 Same vector with 3 bubble cycles between the beats -> out_data=26; dsp_opmode is 8'h09 during the bubbles.
REQ-026 Vectors (1,1,last) then (2,2,last), back-to-back -> results 1 then 4, in order.
REQ-027 out_ready=0 and three 1-element vectors (1,1),(2,2),(3,3) -> in_ready drops after the second is accepted; after raising out_ready, results are 1, 4, 9 and the third vector is accepted only after the first pop.
REQ-028 RSTN pulsed low after beat (7,7) of an open vector, then (1,2,last) -> out_data=2; no stale result is output.
REQ-029 With DOTSEQ_LEN_EN defined, the REQ-024 stimulus -> out_len=2; a 300-beat vector of (1,1) -> out_len=255, out_data=300.
